// File: rtl/mem_bus_arbiter.sv
// Shares the core's single sram-like bus between the fetch and data ports.
// Each access runs an address phase then a data phase; finished results are held until the pipeline advances.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              istall,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              dstall,
  input  logic              hold,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [1:0] SizeWord = 2'd2;

  typedef enum logic [2:0] {IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA} state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } busFields_t;

  state_t     state, stateNext;
  busFields_t busFields;
  logic       iDone, dDone;
  logic       advance;

  // A port stalls until its access has finished within the current pipeline step.
  assign istall  = inst_req & ~iDone;
  assign dstall  = data_req & ~dDone;
  assign advance = ~istall & ~dstall & ~hold;

  assign bus_wr    = busFields.wr;
  assign bus_size  = busFields.size;
  assign bus_addr  = busFields.addr;
  assign bus_wdata = busFields.wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state and bus drive; data port wins ties because its instruction is older.
  always_comb begin
    stateNext = state;
    bus_req   = 1'b0;
    busFields = '0;
    unique case (state)
      IDLE: begin
        if (dstall)      stateNext = D_ADDR;
        else if (istall) stateNext = I_ADDR;
      end
      D_ADDR: begin
        bus_req   = 1'b1;
        busFields = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
        if (bus_addr_ok) stateNext = D_DATA;
      end
      D_DATA: begin
        if (bus_data_ok) stateNext = IDLE;
      end
      I_ADDR: begin
        bus_req   = 1'b1;
        busFields = '{wr: 1'b0, size: SizeWord, addr: inst_addr, wdata: '0};
        if (bus_addr_ok) stateNext = I_DATA;
      end
      I_DATA: begin
        if (bus_data_ok) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Completion flags and returned data; a completion outranks an advance clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      iDone      <= 1'b0;
      dDone      <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      if (state == I_DATA && bus_data_ok) begin
        iDone      <= 1'b1;
        inst_rdata <= bus_rdata;
      end else if (advance) begin
        iDone <= 1'b0;
      end
      if (state == D_DATA && bus_data_ok) begin
        dDone <= 1'b1;
        if (!data_wr) data_rdata <= bus_rdata;
      end else if (advance) begin
        dDone <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, collision, hold, store and mid-access reset.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        istall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        dstall;
  logic        hold;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .istall(istall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .dstall(dstall),
    .hold(hold),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, where new inputs are applied.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
    data_size = 2'd2; data_addr = '0; data_wdata = '0; hold = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

    // Reset state
    cyc(); cyc();
    inst_req = 1'b1; data_req = 1'b1; #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_istall", 32'(istall), 32'd1);
    chk("rst_dstall", 32'(dstall), 32'd1);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    cyc(); rst = 1'b0; inst_req = 1'b0; data_req = 1'b0; #1;
    chk("rst_idle_istall", 32'(istall), 32'd0);

    // Fetch only
    cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00000; #1;
    chk("f_c0_istall", 32'(istall), 32'd1);
    chk("f_c0_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("f_c1_bus_req", 32'(bus_req), 32'd1);
    chk("f_c1_bus_addr", bus_addr, 32'hBFC00000);
    chk("f_c1_bus_wr", 32'(bus_wr), 32'd0);
    chk("f_c1_bus_size", 32'(bus_size), 32'd2);
    chk("f_c1_istall", 32'(istall), 32'd1);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24080001; #1;
    chk("f_c2_bus_req", 32'(bus_req), 32'd0);
    chk("f_c2_istall", 32'(istall), 32'd1);
    cyc(); bus_data_ok = 1'b0; #1;
    chk("f_c3_istall", 32'(istall), 32'd0);
    chk("f_c3_inst_rdata", inst_rdata, 32'h24080001);
    chk("f_c3_bus_req", 32'(bus_req), 32'd0);
    inst_req = 1'b0;
    cyc(); #1;
    chk("f_c4_bus_req", 32'(bus_req), 32'd0);
    chk("f_c4_inst_rdata", inst_rdata, 32'h24080001);

    // Collision: data served first, then fetch after one idle cycle
    cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000010; #1;
    chk("c_c0_istall", 32'(istall), 32'd1);
    chk("c_c0_dstall", 32'(dstall), 32'd1);
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("c_d_bus_req", 32'(bus_req), 32'd1);
    chk("c_d_bus_addr", bus_addr, 32'h80000010);
    chk("c_d_bus_wr", 32'(bus_wr), 32'd0);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h11; #1;
    chk("c_d_data_dstall", 32'(dstall), 32'd1);
    chk("c_d_data_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_data_ok = 1'b0; #1;
    chk("c_gap_dstall", 32'(dstall), 32'd0);
    chk("c_gap_istall", 32'(istall), 32'd1);
    chk("c_gap_bus_req", 32'(bus_req), 32'd0);
    chk("c_gap_data_rdata", data_rdata, 32'h11);
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("c_i_bus_req", 32'(bus_req), 32'd1);
    chk("c_i_bus_addr", bus_addr, 32'hBFC00004);
    chk("c_i_dstall", 32'(dstall), 32'd0);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h22; #1;
    chk("c_i_data_istall", 32'(istall), 32'd1);
    cyc(); bus_data_ok = 1'b0; #1;
    chk("c_end_istall", 32'(istall), 32'd0);
    chk("c_end_dstall", 32'(dstall), 32'd0);
    chk("c_end_inst_rdata", inst_rdata, 32'h22);
    chk("c_end_data_rdata", data_rdata, 32'h11);
    inst_req = 1'b0; data_req = 1'b0;

    // Hold: a finished fetch is not reissued while another stage stalls
    cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00008; #1;
    chk("h_c0_istall", 32'(istall), 32'd1);
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("h_c1_bus_req", 32'(bus_req), 32'd1);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h33; #1;
    cyc(); bus_data_ok = 1'b0; hold = 1'b1; #1;
    chk("h_done_istall", 32'(istall), 32'd0);
    chk("h_done_inst_rdata", inst_rdata, 32'h33);
    for (int i = 1; i < 4; i++) begin
      cyc(); #1;
      chk("h_hold_bus_req", 32'(bus_req), 32'd0);
      chk("h_hold_istall", 32'(istall), 32'd0);
      chk("h_hold_inst_rdata", inst_rdata, 32'h33);
    end
    cyc(); hold = 1'b0; #1;
    chk("h_release_istall", 32'(istall), 32'd0);
    cyc(); #1;
    chk("h_refetch_istall", 32'(istall), 32'd1);
    chk("h_refetch_idle", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("h_refetch_bus_req", 32'(bus_req), 32'd1);
    chk("h_refetch_bus_addr", bus_addr, 32'hBFC00008);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h44; #1;
    cyc(); bus_data_ok = 1'b0; #1;
    chk("h_refetch_done", 32'(istall), 32'd0);
    chk("h_refetch_rdata", inst_rdata, 32'h44);
    inst_req = 1'b0;

    // Store with addr_ok delayed two cycles
    cyc(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h80000020; data_wdata = 32'hAB; #1;
    chk("s_c0_dstall", 32'(dstall), 32'd1);
    chk("s_c0_bus_req", 32'(bus_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); bus_addr_ok = (i == 2); #1;
      chk("s_addr_bus_req", 32'(bus_req), 32'd1);
      chk("s_addr_bus_wr", 32'(bus_wr), 32'd1);
      chk("s_addr_bus_size", 32'(bus_size), 32'd0);
      chk("s_addr_bus_wdata", bus_wdata, 32'hAB);
      chk("s_addr_bus_addr", bus_addr, 32'h80000020);
    end
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF; #1;
    chk("s_data_dstall", 32'(dstall), 32'd1);
    chk("s_data_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_data_ok = 1'b0; #1;
    chk("s_done_dstall", 32'(dstall), 32'd0);
    chk("s_done_data_rdata", data_rdata, 32'h11);
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2;

    // Reset during I_DATA, then a stray data_ok
    cyc(); inst_req = 1'b1; inst_addr = 32'hBFC0000C; #1;
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("r_addr_bus_req", 32'(bus_req), 32'd1);
    cyc(); bus_addr_ok = 1'b0; rst = 1'b1; #1;
    chk("r_idata_istall", 32'(istall), 32'd1);
    cyc(); rst = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h55; #1;
    chk("r_after_bus_req", 32'(bus_req), 32'd0);
    chk("r_after_istall", 32'(istall), 32'd1);
    chk("r_after_inst_rdata", inst_rdata, 32'h0);
    chk("r_after_data_rdata", data_rdata, 32'h0);
    cyc(); bus_data_ok = 1'b0; #1;
    chk("r_stray_istall", 32'(istall), 32'd1);
    chk("r_stray_inst_rdata", inst_rdata, 32'h0);
    chk("r_new_bus_req", 32'(bus_req), 32'd1);
    chk("r_new_bus_addr", bus_addr, 32'hBFC0000C);
    bus_addr_ok = 1'b1;
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h66; #1;
    chk("r_new_data_istall", 32'(istall), 32'd1);
    cyc(); bus_data_ok = 1'b0; #1;
    chk("r_new_done_istall", 32'(istall), 32'd0);
    chk("r_new_inst_rdata", inst_rdata, 32'h66);
    inst_req = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single shared sram-like bus port of the CPU core between the instruction-fetch port (F stage) and the data port (M stage).
- Sequences each access through an address phase and a data phase.
- Drives istall/dstall into the hazard unit, which stalls the pipeline.
- Latches returned read data until the whole pipeline advances, so a finished access is never re-issued while the other port or a divide is still stalling.

Parameters:
ADDR_W, 32, address width of both ports and the bus
DATA_W, 32, data width of both ports and the bus

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
inst_req  in  1  fetch request; held stable by F stage while stalled
inst_addr  in  ADDR_W  fetch address
inst_rdata  out  DATA_W  registered fetch data
istall  out  1  fetch not yet complete
data_req  in  1  load/store request; held stable by M stage while stalled
data_wr  in  1  1 = store
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  registered load data
dstall  out  1  data access not yet complete
hold  in  1  other pipeline stalls (e.g. stall_divE), excluding istall/dstall
bus_req  out  1  bus address-phase request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  address accepted
bus_data_ok  in  1  data returned / write done
bus_rdata  in  DATA_W  bus read data

Behaviour:
- States: IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA. State is registered.
- Reset: state = IDLE; i_done = d_done = 0; inst_rdata = data_rdata = 0; so bus_req = 0, istall = inst_req, dstall = data_req.
- istall = inst_req & ~i_done; dstall = data_req & ~d_done. Both are combinational.
- IDLE:
  - If dstall, go to D_ADDR.
  - Else if istall, go to I_ADDR.
  - Fixed priority: data first, because the M-stage instruction is older.
  - bus_req = 0.
- D_ADDR / I_ADDR:
  - bus_req = 1.
  - Bus fields are muxed combinationally from the selected port.
  - Instruction access is always bus_wr = 0, bus_size = 2, bus_wdata = 0.
  - On bus_addr_ok, go to D_DATA / I_DATA. Otherwise stay, with fields held.
- D_DATA / I_DATA:
  - bus_req = 0.
  - On bus_data_ok: if the access is a read, latch bus_rdata into data_rdata / inst_rdata; set d_done / i_done; go to IDLE.
  - Stores also wait for bus_data_ok; data_rdata is unchanged on a store.
- Latency from IDLE with an idle bus: cycle 0 request seen; cycle 1 bus_req; addr_ok in cycle 1 → data_ok earliest in cycle 2 → stall low in cycle 3. Minimum stall is 3 cycles.
- Advance:
  - Advance = ~istall & ~dstall & ~hold.
  - When advance is true at a clock edge, clear both i_done and d_done. The next instruction then issues a fresh access.
  - A done flag whose request is low is also cleared by advance.
- Done flags are set only by bus_data_ok. Within a cycle, set has priority over clear; this cannot coincide, because a port in its DATA state is stalling.
- Simultaneous inst_req and data_req:
  - Data is served fully first, then instruction, with one IDLE cycle between them.
  - inst_rdata is retained if the instruction was already done while data is still pending.
- Ignored inputs:
  - bus_data_ok in IDLE or either ADDR state is ignored. The bus guarantees data_ok no earlier than the cycle after addr_ok.
  - bus_addr_ok in IDLE or either DATA state is ignored.
- At most one bus transaction is outstanding at any time.
- Reset mid-transaction: returns to IDLE immediately. A late data_ok after reset arrives in IDLE and is ignored.
- A request dropping mid-transaction is not supported. Once in an ADDR state, the access completes.

Test Plan:
- Fetch only: inst_req = 1, inst_addr = 0xBFC00000, addr_ok in the first bus_req cycle, data_ok one cycle later with 0x24080001 → istall high 3 cycles, then inst_rdata = 0x24080001 and istall = 0; bus_req high exactly 1 cycle with bus_addr = 0xBFC00000.
- Collision: inst_req and data_req (load 0x80000010) rise together; bus returns 0x11 for data and 0x22 for fetch → bus order is data then instruction. dstall falls first, istall stays high until the fetch data returns. Final outputs: data_rdata = 0x11, inst_rdata = 0x22.
- Hold: fetch completes while hold = 1 for 4 cycles → no second bus_req; inst_rdata is stable; i_done clears on the first edge with hold = 0. The next cycle, with inst_req still high, issues a new fetch.
- Store: data_wr = 1, data_size = 0, data_wdata = 0xAB, addr_ok delayed 2 cycles → bus_wr = 1, bus_size = 0, bus_wdata = 0xAB held for 3 cycles; data_rdata unchanged; dstall falls the cycle after data_ok.
- Reset in I_DATA, with a stray data_ok the cycle after reset → state IDLE; inst_rdata = 0; istall = inst_req; no done flag set.
